lap_stop_watch_core: RTL and testbench
======================================

// Module: lap_stop_watch_core
// PURPOSE
//  Parametrised stopwatch core: BCD time counter (min:sec.cs) with run/stop/clear and a lap-capture buffer.
//  Includes lap recall and a multiplexed NUM_DIGITS seven-segment scanner.
//  Sits between the button/state-control logic and the board display pins.
//  Counts directly in BCD, so no hex-to-BCD converter is needed downstream.
// PARAMETERS
//  CLK_HZ     100_000_000  input clock frequency
//  TICK_HZ    100          count rate (centisecond tick)
//  SCAN_HZ    1000         digit-advance rate of the display scanner
//  NUM_DIGITS 4            display digits; legal values 4 or 6
//  LAP_DEPTH  8            lap buffer entries (power of 2)
//  LAP_AW     3            log2(LAP_DEPTH)
// PORTS
//  clk        in   1           system clock
//  rst        in   1           asynchronous reset, active-low
//  run_btn    in   1           synchronised level; rising edge toggles run/stop
//  lap_btn    in   1           synchronised level; rising edge = capture lap (LIVE) or step index (RECALL)
//  clr_btn    in   1           synchronised level; rising edge = clear (accepted only when stopped)
//  rcl_btn    in   1           synchronised level; rising edge toggles LIVE/RECALL view
//  disp_md    in   1           NUM_DIGITS=4 only: 0 = SS.cc, 1 = MM.SS
//  an         out  NUM_DIGITS  digit enables, active-low
//  seg        out  7           segments {g..a}, active-low
//  dp         out  1           decimal point, active-low
//  running    out  1           1 while counting
//  recall     out  1           1 in RECALL view
//  lap_cnt    out  LAP_AW+1    number of stored laps
//  lap_idx    out  LAP_AW      entry shown in RECALL
//  ovf        out  1           sticky: time wrapped past 99:59.99
// BEHAVIOUR
//  Reset (async, rst=0) values:
//   - time = 00:00.00; running = recall = ovf = 0; lap_cnt = lap_idx = 0; all dividers = 0.
//   - an = all 1; seg = 7'h7f; dp = 1.
//  Button handling:
//   - Each button is edge-detected with one register stage; its action takes effect the cycle after the rising edge is seen.
//  Tick divider:
//   - Counts 0..CLK_HZ/TICK_HZ-1 only while running; a one-cycle tick fires at the terminal count.
//   - The divider holds its value when stopped and zeroes on clear.
//  Counter:
//   - cs BCD 00..99 -> sec BCD 00..59 -> min BCD 00..99, one cs step per tick.
//   - At 99:59.99 a tick wraps time to 00:00.00 and sets ovf; counting continues.
//  Run FSM:
//   - States STOP and RUN; run edge toggles between them.
//   - clr edge in STOP: time = 0, divider = 0, ovf = 0, lap_cnt = 0, lap_idx = 0, recall = 0.
//   - clr edge in RUN: ignored.
//  Lap capture (LIVE view, RUN state):
//   - A lap edge writes the current time into entry lap_cnt and increments lap_cnt.
//   - Lap and tick in the same cycle: the pre-increment time is stored.
//   - Buffer full (lap_cnt = LAP_DEPTH): the capture is dropped and lap_cnt holds. There is no overwrite.
//   - A lap edge in STOP is ignored.
//  View FSM:
//   - States LIVE and RECALL; rcl edge toggles between them.
//   - Entering RECALL with lap_cnt = 0 is refused; the view stays LIVE.
//   - Entering RECALL sets lap_idx = 0.
//   - In RECALL, a lap edge steps lap_idx modulo lap_cnt (lap_cnt-1 -> 0) and performs no capture.
//   - Counting continues underneath the RECALL view.
//  Display source: RECALL shows lap[lap_idx]; LIVE shows the live time.
//  Display formats:
//   - NUM_DIGITS = 6: MM.SS.cc; dp on digits 4 and 2, counted from the right starting at 1.
//   - NUM_DIGITS = 4, disp_md = 0: SS.cc.
//   - NUM_DIGITS = 4, disp_md = 1: MM.SS.
//   - In both 4-digit formats the dp is on digit 3, plus the rightmost dp when in RECALL.
//  Scanner:
//   - A free-running divider produces a one-cycle strobe every CLK_HZ/SCAN_HZ clocks.
//   - On each strobe the digit pointer advances from leftmost to rightmost and wraps.
//   - an, seg and dp are registered together on the strobe, so the display lags a source change by up to NUM_DIGITS strobes.
//   - Exactly one an bit is low after the first strobe.
//  Reset mid-operation:
//   - Everything returns to its reset value immediately, including lap contents (lap_cnt = 0).
//   - No output glitch beyond the reset values.
// TESTING (sim params: CLK_HZ=1000, TICK_HZ=100, SCAN_HZ=250, NUM_DIGITS=4, LAP_DEPTH=4)
//  1. Reset, run edge, wait 1000 clks -> time = 00:01.00; SS.cc displays 0,1,0,0 with an 0111,1011,1101,1110 in order, dp low on the 2nd digit.
//  2. Preload time to 99:59.99 via 599,999 ticks, then 1 more tick -> time = 00:00.00, ovf = 1; stop + clr -> ovf = 0.
//  3. Run, send 5 lap edges at 20-tick spacing -> lap_cnt = 4, entries 00:00.20/.40/.60/.80, 5th capture dropped.
//  4. Force lap edge on the tick cycle at 00:00.49 -> stored entry 00:00.49, live time 00:00.50.
//  5. RECALL with lap_cnt = 3: 4 lap edges -> lap_idx 1, 2, 0, 1; live time keeps advancing; rcl with lap_cnt = 0 -> recall stays 0.
//  6. clr edge while running -> ignored. Async rst pulse mid-scan -> an = 4'hf, seg = 7'h7f, lap_cnt = 0 in the same cycle.

Source files
------------

// File: rtl/lap_stop_watch_core.sv
// Stopwatch core: BCD MM:SS.cc counter with run/stop/clear, a lap buffer with recall,
// and a multiplexed seven-segment scanner driving active-low display pins.
module lap_stop_watch_core #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 100,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int LAP_DEPTH  = 8,
    parameter int LAP_AW     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_btn,
    input  logic                  lap_btn,
    input  logic                  clr_btn,
    input  logic                  rcl_btn,
    input  logic                  disp_md,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  running,
    output logic                  recall,
    output logic [LAP_AW:0]       lap_cnt,
    output logic [LAP_AW-1:0]     lap_idx,
    output logic                  ovf
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TDW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SDW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PW       = $clog2(NUM_DIGITS);
    localparam logic [23:0] T_MAX = 24'h99_59_99;

    typedef enum logic {ST_STOP, ST_RUN} run_st_t;
    typedef enum logic {VW_LIVE, VW_RECALL} view_t;

    run_st_t               r_run_st;
    view_t                 r_view;
    logic                  r_run_q, r_lap_q, r_clr_q, r_rcl_q;
    logic [TDW-1:0]        r_tdiv;
    logic [23:0]           r_time;
    logic                  r_ovf;
    logic [LAP_AW:0]       r_lap_cnt;
    logic [LAP_AW-1:0]     r_lap_idx;
    logic [23:0]           r_laps [LAP_DEPTH];
    logic [SDW-1:0]        r_sdiv;
    logic [PW-1:0]         r_ptr;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    logic                  w_run_e, w_lap_e, w_clr_e, w_rcl_e;
    logic                  w_tick, w_strobe, w_lap_full, w_idx_last;
    logic [23:0]           w_src;
    logic [3:0]            w_digit;
    logic [NUM_DIGITS-1:0] w_an;
    logic                  w_dp_on;
    int                    w_pos;

    // One centisecond step with BCD carries cs -> sec (00..59) -> min, wrapping at 99:59.99.
    function automatic logic [23:0] time_inc(input logic [23:0] t);
        logic [23:0] n;
        n = t;
        if (t[3:0] != 4'd9) n[3:0] = t[3:0] + 4'd1;
        else begin
            n[3:0] = 4'd0;
            if (t[7:4] != 4'd9) n[7:4] = t[7:4] + 4'd1;
            else begin
                n[7:4] = 4'd0;
                if (t[11:8] != 4'd9) n[11:8] = t[11:8] + 4'd1;
                else begin
                    n[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) n[15:12] = t[15:12] + 4'd1;
                    else begin
                        n[15:12] = 4'd0;
                        if (t[19:16] != 4'd9) n[19:16] = t[19:16] + 4'd1;
                        else begin
                            n[19:16] = 4'd0;
                            n[23:20] = (t[23:20] != 4'd9) ? t[23:20] + 4'd1 : 4'd0;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] on;
        case (d)
            4'd0:    on = 7'h3f;
            4'd1:    on = 7'h06;
            4'd2:    on = 7'h5b;
            4'd3:    on = 7'h4f;
            4'd4:    on = 7'h66;
            4'd5:    on = 7'h6d;
            4'd6:    on = 7'h7d;
            4'd7:    on = 7'h07;
            4'd8:    on = 7'h7f;
            4'd9:    on = 7'h6f;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

    assign w_run_e    = run_btn & ~r_run_q;
    assign w_lap_e    = lap_btn & ~r_lap_q;
    assign w_clr_e    = clr_btn & ~r_clr_q;
    assign w_rcl_e    = rcl_btn & ~r_rcl_q;
    assign w_tick     = (r_run_st == ST_RUN) && (r_tdiv == TDW'(TICK_DIV - 1));
    assign w_strobe   = (r_sdiv == SDW'(SCAN_DIV - 1));
    assign w_lap_full = (r_lap_cnt == (LAP_AW+1)'(LAP_DEPTH));
    assign w_idx_last = ({1'b0, r_lap_idx} == r_lap_cnt - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_q   <= 1'b0;
            r_lap_q   <= 1'b0;
            r_clr_q   <= 1'b0;
            r_rcl_q   <= 1'b0;
            r_run_st  <= ST_STOP;
            r_view    <= VW_LIVE;
            r_tdiv    <= '0;
            r_time    <= '0;
            r_ovf     <= 1'b0;
            r_lap_cnt <= '0;
            r_lap_idx <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) r_laps[i] <= '0;
        end else begin
            r_run_q <= run_btn;
            r_lap_q <= lap_btn;
            r_clr_q <= clr_btn;
            r_rcl_q <= rcl_btn;
            if (w_run_e) r_run_st <= (r_run_st == ST_RUN) ? ST_STOP : ST_RUN;
            if (r_run_st == ST_RUN) begin
                if (w_tick) begin
                    r_tdiv <= '0;
                    r_time <= time_inc(r_time);
                    if (r_time == T_MAX) r_ovf <= 1'b1;
                end else begin
                    r_tdiv <= r_tdiv + 1'b1;
                end
            end
            // Captures store the register value, i.e. the time before a same-cycle tick.
            if (r_view == VW_LIVE) begin
                if (w_lap_e && (r_run_st == ST_RUN) && !w_lap_full) begin
                    r_laps[r_lap_cnt[LAP_AW-1:0]] <= r_time;
                    r_lap_cnt <= r_lap_cnt + 1'b1;
                end
                if (w_rcl_e && (r_lap_cnt != '0)) begin
                    r_view    <= VW_RECALL;
                    r_lap_idx <= '0;
                end
            end else begin
                if (w_lap_e) r_lap_idx <= w_idx_last ? '0 : r_lap_idx + 1'b1;
                if (w_rcl_e) r_view <= VW_LIVE;
            end
            if (w_clr_e && (r_run_st == ST_STOP)) begin
                r_time    <= '0;
                r_tdiv    <= '0;
                r_ovf     <= 1'b0;
                r_lap_cnt <= '0;
                r_lap_idx <= '0;
                r_view    <= VW_LIVE;
            end
        end
    end

    // w_pos is the digit position counted from the right, starting at 1.
    always_comb begin
        w_src = (r_view == VW_RECALL) ? r_laps[r_lap_idx] : r_time;
        w_pos = NUM_DIGITS - int'(r_ptr);
        if (NUM_DIGITS == 6)  w_digit = 4'(w_src >> (4 * (w_pos - 1)));
        else if (disp_md)     w_digit = 4'(w_src >> (4 * (w_pos + 1)));
        else                  w_digit = 4'(w_src >> (4 * (w_pos - 1)));
        w_an = ~(NUM_DIGITS'(1) << (w_pos - 1));
        if (NUM_DIGITS == 6) w_dp_on = (w_pos == 4) || (w_pos == 2);
        else                 w_dp_on = (w_pos == 3) || ((w_pos == 1) && (r_view == VW_RECALL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sdiv <= '0;
            r_ptr  <= '0;
            r_an   <= '1;
            r_seg  <= 7'h7f;
            r_dp   <= 1'b1;
        end else if (w_strobe) begin
            r_sdiv <= '0;
            r_an   <= w_an;
            r_seg  <= seg_enc(w_digit);
            r_dp   <= ~w_dp_on;
            r_ptr  <= (r_ptr == PW'(NUM_DIGITS - 1)) ? '0 : r_ptr + 1'b1;
        end else begin
            r_sdiv <= r_sdiv + 1'b1;
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign dp      = r_dp;
    assign running = (r_run_st == ST_RUN);
    assign recall  = (r_view == VW_RECALL);
    assign lap_cnt = r_lap_cnt;
    assign lap_idx = r_lap_idx;
    assign ovf     = r_ovf;
endmodule

// File: tb/tb_lap_stop_watch_core.sv
// Bench for lap_stop_watch_core: directed scenarios plus random button traffic, checked
// against an elapsed-cycle model of the stopwatch and by decoding the scanned display.
module tb_lap_stop_watch_core;
    localparam int DIV = 10;
    localparam int DEPTH = 4;
    localparam int B_RUN = 0, B_LAP = 1, B_CLR = 2, B_RCL = 3;

    logic clk = 1'b0, rst = 1'b0;
    logic run_btn = 1'b0, lap_btn = 1'b0, clr_btn = 1'b0, rcl_btn = 1'b0, disp_md = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp, running, recall, ovf;
    logic [2:0] lap_cnt;
    logic [1:0] lap_idx;

    int checks = 0;
    int errors = 0;

    lap_stop_watch_core #(
        .CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250),
        .NUM_DIGITS(4), .LAP_DEPTH(DEPTH), .LAP_AW(2)
    ) dut (
        .clk(clk), .rst(rst),
        .run_btn(run_btn), .lap_btn(lap_btn), .clr_btn(clr_btn), .rcl_btn(rcl_btn),
        .disp_md(disp_md),
        .an(an), .seg(seg), .dp(dp),
        .running(running), .recall(recall),
        .lap_cnt(lap_cnt), .lap_idx(lap_idx), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Model: time is the number of clock edges spent running since the last clear,
    // divided by the tick period, plus an optional preload offset, in centiseconds.
    int  m_n = 0;
    bit  m_run = 0, m_rcl = 0;
    int  m_idx = 0;
    int  m_laps[$];
    int  m_clr_cnt = 0;
    int  m_off = 0;
    int  m_off_ep = -1;
    bit  p_run = 0, p_lap = 0, p_clr = 0, p_rcl = 0;
    bit  e_run, e_lap, e_clr, e_rcl;

    function automatic int m_total();
        return ((m_off_ep == m_clr_cnt) ? m_off : 0) + m_n / DIV;
    endfunction
    function automatic int m_time();
        return m_total() % 600000;
    endfunction
    function automatic bit m_ovf();
        return m_total() >= 600000;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n = 0; m_run = 0; m_rcl = 0; m_idx = 0;
            m_laps.delete();
            m_clr_cnt = m_clr_cnt + 1;
            p_run = 0; p_lap = 0; p_clr = 0; p_rcl = 0;
        end else begin
            e_run = run_btn && !p_run;
            e_lap = lap_btn && !p_lap;
            e_clr = clr_btn && !p_clr;
            e_rcl = rcl_btn && !p_rcl;
            if (m_rcl) begin
                if (e_lap) m_idx = (m_idx + 1) % m_laps.size();
                if (e_rcl) m_rcl = 0;
            end else begin
                if (e_lap && m_run && m_laps.size() < DEPTH) m_laps.push_back(m_time());
                if (e_rcl && m_laps.size() > 0) begin m_rcl = 1; m_idx = 0; end
            end
            if (m_run) m_n = m_n + 1;
            if (e_clr && !m_run) begin
                m_n = 0; m_idx = 0; m_rcl = 0;
                m_laps.delete();
                m_clr_cnt = m_clr_cnt + 1;
            end
            if (e_run) m_run = !m_run;
            p_run = run_btn; p_lap = lap_btn; p_clr = clr_btn; p_rcl = rcl_btn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
        checks++;
        assert (obsv === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obsv, expv);
        end
    endtask

    task automatic press(input int b);
        case (b)
            B_RUN:   run_btn = 1'b1;
            B_LAP:   lap_btn = 1'b1;
            B_CLR:   clr_btn = 1'b1;
            default: rcl_btn = 1'b1;
        endcase
        @(negedge clk);
        run_btn = 1'b0; lap_btn = 1'b0; clr_btn = 1'b0; rcl_btn = 1'b0;
    endtask

    function automatic logic [3:0] seg_dec(input logic [6:0] s);
        case (s)
            7'h40: return 4'd0;
            7'h79: return 4'd1;
            7'h24: return 4'd2;
            7'h30: return 4'd3;
            7'h19: return 4'd4;
            7'h12: return 4'd5;
            7'h02: return 4'd6;
            7'h78: return 4'd7;
            7'h00: return 4'd8;
            7'h10: return 4'd9;
            default: return 4'hf;
        endcase
    endfunction

    function automatic logic [15:0] bcd4(input int t, input bit md);
        int mm, ss, cc;
        mm = t / 6000; ss = (t / 100) % 60; cc = t % 100;
        if (md) return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        return {4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    // Watches 24 clocks of scanning; digits/dps are packed leftmost digit first.
    task automatic read_disp(output logic [15:0] digs, output logic [3:0] dps, output bit seq_ok);
        logic [3:0] prev_an;
        int nchg;
        digs = '1; dps = '1; seq_ok = 1; nchg = 0;
        prev_an = an;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (an != prev_an) begin
                if (nchg > 0 && an != {prev_an[0], prev_an[3:1]}) seq_ok = 0;
                nchg++;
                prev_an = an;
            end
            case (an)
                4'b0111: begin digs[15:12] = seg_dec(seg); dps[3] = dp; end
                4'b1011: begin digs[11:8]  = seg_dec(seg); dps[2] = dp; end
                4'b1101: begin digs[7:4]   = seg_dec(seg); dps[1] = dp; end
                4'b1110: begin digs[3:0]   = seg_dec(seg); dps[0] = dp; end
                default: seq_ok = 0;
            endcase
        end
        if (nchg < 4) seq_ok = 0;
    endtask

    task automatic check_disp(input string tag, output logic [15:0] d0, output logic [15:0] d1);
        logic [15:0] d;
        logic [3:0] p;
        bit ok;
        int src;
        src = m_rcl ? m_laps[m_idx] : m_time();
        for (int md = 0; md < 2; md++) begin
            disp_md = (md == 1);
            repeat (20) @(negedge clk);
            read_disp(d, p, ok);
            chk({tag, "_digits"}, d, bcd4(src, md == 1));
            chk({tag, "_dp"}, p, m_rcl ? 4'b1010 : 4'b1011);
            chk({tag, "_scan"}, ok, 1);
            if (md == 0) d0 = d; else d1 = d;
        end
        disp_md = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_running"}, running, m_run);
        chk({tag, "_recall"}, recall, m_rcl);
        chk({tag, "_lap_cnt"}, lap_cnt, m_laps.size());
        chk({tag, "_lap_idx"}, lap_idx, m_idx);
        chk({tag, "_ovf"}, ovf, m_ovf());
    endtask

    initial begin
        logic [15:0] d0, d1;
        int exp_idx[4];
        exp_idx = '{1, 2, 0, 1};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'hf);
        chk("rst_seg", seg, 7'h7f);
        chk("rst_dp", dp, 1'b1);
        chk_status("rst");
        chk("rst_lap_cnt_zero", lap_cnt, 0);
        rst = 1'b1;
        @(negedge clk);

        // 1000 running clocks -> 00:01.00
        press(B_RUN);
        chk("t1_running", running, 1'b1);
        repeat (999) @(negedge clk);
        press(B_RUN);
        chk_status("t1");
        check_disp("t1", d0, d1);
        chk("t1_sscc", d0, 16'h0100);
        chk("t1_mmss", d1, 16'h0001);

        // Preload 99:59.99, one more tick wraps and sets ovf
        press(B_CLR);
        force dut.r_time = 24'h99_59_99;
        @(negedge clk);
        release dut.r_time;
        m_off = 599999;
        m_off_ep = m_clr_cnt;
        check_disp("t2_pre", d0, d1);
        chk("t2_pre_mmss", d1, 16'h9959);
        press(B_RUN);
        repeat (12) @(negedge clk);
        press(B_RUN);
        chk_status("t2");
        chk("t2_ovf_set", ovf, 1'b1);
        check_disp("t2_wrap", d0, d1);
        chk("t2_wrap_sscc", d0, 16'h0000);
        press(B_CLR);
        chk("t2_ovf_clr", ovf, 1'b0);

        // Five laps at 20-tick spacing; the fifth is dropped
        press(B_RUN);
        repeat (200) @(negedge clk);
        press(B_LAP);
        for (int k = 0; k < 4; k++) begin
            repeat (199) @(negedge clk);
            press(B_LAP);
        end
        chk_status("t3");
        chk("t3_lap_cnt_full", lap_cnt, 3'd4);
        press(B_RCL);
        for (int k = 0; k < 4; k++) begin
            check_disp($sformatf("t3_entry%0d", k), d0, d1);
            chk($sformatf("t3_entry%0d_lit", k), d0, bcd4((k + 1) * 20, 0));
            press(B_LAP);
        end
        press(B_RCL);
        press(B_RUN);

        // Lap on the tick edge at 00:00.49
        press(B_CLR);
        press(B_RUN);
        repeat (499) @(negedge clk);
        press(B_LAP);
        press(B_RUN);
        check_disp("t4_live", d0, d1);
        chk("t4_live_lit", d0, 16'h0050);
        press(B_RCL);
        check_disp("t4_lap", d0, d1);
        chk("t4_lap_lit", d0, 16'h0049);
        press(B_RCL);

        // Recall stepping with three laps; counting continues underneath
        press(B_CLR);
        press(B_RUN);
        for (int k = 0; k < 3; k++) begin
            repeat (7) @(negedge clk);
            press(B_LAP);
        end
        press(B_RCL);
        chk_status("t5_enter");
        for (int k = 0; k < 4; k++) begin
            repeat (5) @(negedge clk);
            press(B_LAP);
            chk($sformatf("t5_idx%0d", k), lap_idx, exp_idx[k]);
            chk_status($sformatf("t5_step%0d", k));
        end
        press(B_RCL);
        press(B_RUN);
        check_disp("t5_live", d0, d1);
        press(B_CLR);
        press(B_RCL);
        chk("t5_rcl_empty", recall, 1'b0);
        chk_status("t5_empty");

        // Clear while running is ignored
        press(B_RUN);
        repeat (30) @(negedge clk);
        press(B_LAP);
        press(B_CLR);
        chk_status("t6_clr_run");
        press(B_RUN);
        check_disp("t6_after_clr", d0, d1);

        // Random button traffic
        for (int it = 0; it < 80; it++) begin
            press($urandom_range(0, 3));
            repeat ($urandom_range(0, 25)) @(negedge clk);
            chk_status($sformatf("rnd%0d", it));
        end
        if (m_rcl) check_disp("rnd_recall", d0, d1);
        if (m_rcl) press(B_RCL);
        if (m_run) press(B_RUN);
        check_disp("rnd_end", d0, d1);

        // Asynchronous reset mid-scan
        if (!m_run) press(B_RUN);
        repeat (3) @(negedge clk);
        press(B_LAP);
        repeat (10) @(negedge clk);
        chk_status("t6_pre_rst");
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_an", an, 4'hf);
        chk("t6_rst_seg", seg, 7'h7f);
        chk("t6_rst_dp", dp, 1'b1);
        chk("t6_rst_lap_cnt", lap_cnt, 3'd0);
        chk_status("t6_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk_status("t6_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
